// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode table, instruction field positions and FSM encoding shared by the
// fetch sequencer, the ALU side and the bench.
package fetch_pkg;
  localparam logic [3:0] OP_ADD = 4'd0, OP_AND = 4'd1, OP_EQ = 4'd2, OP_GT = 4'd3;
  localparam logic [3:0] OP_SHL1 = 4'd4, OP_SHR1 = 4'd5, OP_SUB = 4'd6, OP_HALT = 4'd15;
  localparam int OPC_HI = 31, OPC_LO = 28, RD_HI = 27, RD_LO = 23;
  localparam int RS_HI = 22, RS_LO = 18, RT_HI = 17, RT_LO = 13;
  typedef enum logic [1:0] {FETCH, DECODE, ISSUE, HALT} state_t;
endpackage

// File: rtl/unidad_fetch_decodificador.sv
// decodificador: classifies an opcode as ALU operator, reserved (illegal) or HALT.
module decodificador
  import fetch_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [3:0] operador,
  output logic       es_ilegal,
  output logic       es_halt
);
  assign es_halt   = opcode == OP_HALT;
  assign es_ilegal = opcode > OP_SUB && !es_halt;
  assign operador  = (es_ilegal || es_halt) ? OP_ADD : opcode;
endmodule

// File: rtl/unidad_fetch.sv
// unidad_fetch: PC/IR fetch-decode sequencer feeding the ALU over valid/ready.
// Optional UNIDAD_FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module unidad_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [3:0]        operador,
  output logic [4:0]        rd,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
`ifdef UNIDAD_FETCH_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              illegal
);
  state_t            state_q;
  logic [ADDR_W-1:0] pc_q, pc_out_q, pc_inc;
  logic [31:0]       ir_q;
  logic [3:0]        operador_q, op_dec;
  logic [4:0]        rd_q, rs_q, rt_q;
  logic              halted_q, illegal_q, es_ilegal, es_halt, unused_bits;

  decodificador u_dec (
    .opcode   (ir_q[OPC_HI:OPC_LO]),
    .operador (op_dec),
    .es_ilegal(es_ilegal),
    .es_halt  (es_halt)
  );

  assign pc_inc      = pc_q + ADDR_W'(PC_STEP);
  assign unused_bits = ^ir_q[RT_LO-1:0];
  // rst_n gates the request so it drops the moment reset is asserted
  assign mem_req   = rst_n && state_q == FETCH;
  assign mem_addr  = pc_q;
  assign dec_valid = state_q == ISSUE;
  assign operador  = operador_q;
  assign rd        = rd_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign pc_out    = pc_out_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pc_out_q   <= '0;
      ir_q       <= '0;
      operador_q <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else
      case (state_q)
        FETCH: if (mem_ack) begin
          ir_q    <= mem_rdata;
          state_q <= DECODE;
        end
        DECODE: if (es_halt) begin
          halted_q <= 1'b1;
          state_q  <= HALT;
        end else if (es_ilegal) begin
          illegal_q <= 1'b1;
          pc_q      <= pc_inc;
          state_q   <= FETCH;
        end else begin
          operador_q <= op_dec;
          rd_q       <= ir_q[RD_HI:RD_LO];
          rs_q       <= ir_q[RS_HI:RS_LO];
          rt_q       <= ir_q[RT_HI:RT_LO];
          pc_out_q   <= pc_q;
          state_q    <= ISSUE;
        end
        ISSUE: if (dec_ready) begin
          pc_q    <= pc_inc;
          state_q <= FETCH;
        end
        default: state_q <= HALT;
      endcase

`ifdef UNIDAD_FETCH_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_q <= '0;
    else if (((state_q == FETCH && !mem_ack) || (state_q == ISSUE && !dec_ready)) && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_unidad_fetch.sv
// tb_unidad_fetch: program-walk model predicts fetch addresses and issued instructions;
// one compare process checks every handshake and every stalled cycle against it.
module tb_unidad_fetch;
  import fetch_pkg::*;
  typedef struct packed {logic [3:0] op; logic [4:0] rd, rs, rt; logic [31:0] pc;} iss_t;
  logic clk = 0, rst_n = 0, mem_ack = 0, dec_ready = 0;
  logic mem_req, dec_valid, halted, illegal;
  logic [31:0] mem_addr, mem_rdata, pc_out;
  logic [3:0] operador;
  logic [4:0] rd, rs, rt;
  logic mem_req_w, dec_valid_w, halted_w, illegal_w;
  logic [7:0] mem_addr_w, pc_out_w;
  logic [3:0] operador_w;
  logic [4:0] rd_w, rs_w, rt_w;
`ifdef UNIDAD_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt_w;
`endif
  logic [31:0] prog [0:63];
  iss_t iss_q[$], issued[$];
  logic [31:0] fetch_q[$];
  int iss_cyc[$];
  int checks = 0, passed = 0, ack_wait = 0, rdy_wait = 0, cyc = 0;
  bit en = 0, exp_halt = 0, halt_done = 0;

  always #5 clk = ~clk;
  assign mem_rdata = prog[mem_addr[7:2]];

  unidad_fetch dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready), .operador(operador),
    .rd(rd), .rs(rs), .rt(rt),
`ifdef UNIDAD_FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .pc_out(pc_out), .halted(halted), .illegal(illegal)
  );

  unidad_fetch #(.ADDR_W(8), .RESET_PC(8'hFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_req_w),
    .mem_rdata(32'h0), .dec_valid(dec_valid_w), .dec_ready(1'b1), .operador(operador_w),
    .rd(rd_w), .rs(rs_w), .rt(rt_w),
`ifdef UNIDAD_FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt_w),
`endif
    .pc_out(pc_out_w), .halted(halted_w), .illegal(illegal_w)
  );

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] d, s, t);
    return {op, d, s, t, 13'h0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // walk the program as the spec describes it: legal ops issue, reserved skip, HALT stops
  task automatic plan(input logic [31:0] start, input int n);
    logic [31:0] pc, w;
    pc = start;
    iss_q.delete(); fetch_q.delete(); issued.delete(); iss_cyc.delete();
    exp_halt = 0; halt_done = 0;
    for (int i = 0; i < n && !exp_halt; i++) begin
      w = prog[pc[7:2]];
      fetch_q.push_back(pc);
      if (w[31:28] == 4'hF) exp_halt = 1;
      else begin
        if (w[31:28] <= 4'd6) iss_q.push_back({w[31:28], w[27:23], w[22:18], w[17:13], pc});
        pc = pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    en = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; en = 1;
  endtask

  task automatic wait_halt(input int lim);
    for (int i = 0; i < lim && !halt_done; i++) @(negedge clk);
    check("halt_reached", halt_done, 1);
    check("iss_left", iss_q.size(), 0);
  endtask

  initial begin
    int wc = 0, rc = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin mem_ack = wc >= ack_wait; wc++; end else begin mem_ack = 0; wc = 0; end
      if (dec_valid) begin dec_ready = rc >= rdy_wait; rc++; end else begin dec_ready = 0; rc = 0; end
    end
  end

  initial begin
    iss_t cur, prev_b, e;
    logic [31:0] prev_addr;
    bit prev_stall, prev_wait;
    forever begin
      @(negedge clk);
      #3 cyc++;
      cur = {operador, rd, rs, rt, pc_out};
      if (!en) begin prev_stall = 0; prev_wait = 0; continue; end
      if (halt_done) check("halt_idle", {mem_req, dec_valid}, 2'b00);
      if (prev_wait) check("addr_hold", mem_addr, prev_addr);
      if (prev_stall) check("issue_hold", cur, prev_b);
      if (mem_req && mem_ack) begin
        if (fetch_q.size() == 0) begin checks++; $display("FAIL extra_fetch actual=%0h required=none", mem_addr); end
        else check("fetch_addr", mem_addr, fetch_q.pop_front());
        if (fetch_q.size() == 0 && exp_halt) halt_done = 1;
      end
      if (dec_valid && dec_ready) begin
        if (iss_q.size() == 0) begin checks++; $display("FAIL extra_issue actual=%0h required=none", cur); end
        else begin e = iss_q.pop_front(); check("issue", cur, e); end
        issued.push_back(cur); iss_cyc.push_back(cyc);
      end
      prev_stall = dec_valid && !dec_ready; prev_b = cur;
      prev_wait = mem_req && !mem_ack; prev_addr = mem_addr;
    end
  end

  initial begin
    #100000 $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    for (int i = 0; i < 64; i++) prog[i] = 32'hF000_0000;
    #3;
    check("rst_mem_req", mem_req, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_flags", {halted, illegal}, 2'b00);
    check("rst_fields", {operador, rd, rs, rt}, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_mem_addr", mem_addr, 0);
    // PC wrap on the 8-bit instance running zero-wait add instructions
    @(posedge clk);
    #1 rst_n = 1;
    #1 check("wrap_first_addr", mem_addr_w, 8'hFC);
    check("wrap_req", mem_req_w, 1);
    repeat (3) @(posedge clk);
    #1 check("wrap_next_addr", mem_addr_w, 8'h00);
    check("wrap_pc_out", pc_out_w, 8'hFC);
    // sequential zero-wait add/and/sub
    prog[0] = mk(OP_ADD, 1, 2, 3); prog[1] = mk(OP_AND, 4, 5, 6); prog[2] = mk(OP_SUB, 7, 8, 9);
    ack_wait = 0; rdy_wait = 0;
    plan(0, 10); do_reset(); wait_halt(60);
    check("t1_count", issued.size(), 3);
    if (issued.size() == 3) begin
      check("t1_ops", {issued[0].op, issued[1].op, issued[2].op}, 12'h016);
      check("t1_pcs", {issued[0].pc[7:0], issued[1].pc[7:0], issued[2].pc[7:0]}, 24'h000408);
      check("t1_gap1", iss_cyc[1] - iss_cyc[0], 3);
      check("t1_gap2", iss_cyc[2] - iss_cyc[1], 3);
    end
    // wait states and backpressure
    for (int i = 0; i < 64; i++) prog[i] = 32'hF000_0000;
    prog[0] = mk(OP_GT, 5, 6, 7);
    ack_wait = 3; rdy_wait = 2;
    plan(0, 10); do_reset();
    for (int i = 0; i < 40 && issued.size() == 0; i++) begin @(negedge clk); #4; end
    check("t2_issued", issued.size(), 1);
`ifdef UNIDAD_FETCH_STALL_CNT_EN
    check("t2_stall_cnt", stall_cnt, 5);
`endif
    wait_halt(60);
    check("t2_count", issued.size(), 1);
    // reserved opcode then HALT
    prog[0] = 32'h9ABC_DEF0; prog[1] = 32'hF123_4567;
    ack_wait = 0; rdy_wait = 0;
    plan(0, 10); do_reset(); wait_halt(40);
    repeat (20) @(negedge clk);
    check("t3_flags", {halted, illegal}, 2'b11);
    check("t3_none_issued", issued.size(), 0);
    // asynchronous reset while waiting at PC 0x40
    prog[0] = 32'h7000_0000;
    for (int i = 1; i < 20; i++) prog[i] = mk(OP_EQ, 5'(i), 5'd1, 5'd2);
    plan(0, 40); do_reset();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin @(posedge clk); #1 found = mem_req && mem_addr == 32'h40; end
    check("t4_reach_40", found, 1);
    ack_wait = 99;
    @(negedge clk);
    #2 check("t4_illegal_pre", illegal, 1);
    en = 0; rst_n = 0;
    #1 check("t4_req_drop", mem_req, 0);
    check("t4_flags_clr", {halted, illegal}, 2'b00);
    ack_wait = 0;
    @(posedge clk);
    #1 rst_n = 1;
    #1 check("t4_first_addr", mem_addr, 0);
    check("t4_req_up", mem_req, 1);
    // field decode
    for (int i = 0; i < 64; i++) prog[i] = 32'hF000_0000;
    prog[0] = 32'h6888_2000;
    plan(0, 10); do_reset(); wait_halt(40);
    check("t6_count", issued.size(), 1);
    if (issued.size() == 1) begin
      check("t6_op", issued[0].op, 6);
      check("t6_rd", issued[0].rd, 17);
      check("t6_rs", issued[0].rs, 2);
      check("t6_rt", issued[0].rt, 1);
    end
    en = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
